// File: rtl/led_phase_scheduler_if.sv
// Sample stream from the LED phase scheduler to the RED/IR FIR filter pair.
// Each channel is an independent valid/ready handshake carrying one averaged sample.
interface led_phase_scheduler_if;
  logic [7:0] red_sample;
  logic       red_valid;
  logic       red_ready;
  logic [7:0] ir_sample;
  logic       ir_valid;
  logic       ir_ready;

  modport master (
    output red_sample, red_valid, ir_sample, ir_valid,
    input  red_ready, ir_ready
  );

  modport slave (
    input  red_sample, red_valid, ir_sample, ir_valid,
    output red_ready, ir_ready
  );
endinterface

// File: rtl/led_phase_scheduler.sv
// LED phase scheduler: alternates RED and IR illumination phases, applies the
// calibrated DC compensation and PGA gain per phase, waits for the front end to
// settle, averages 2^AVG_LOG2 ADC samples and offers one result per channel
// to the downstream filters.
module led_phase_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        cal_valid,
  input  logic [6:0]                  red_op,
  input  logic [3:0]                  red_gain,
  input  logic [6:0]                  ir_op,
  input  logic [3:0]                  ir_gain,
  input  logic [7:0]                  adc,
  output logic                        led_red,
  output logic                        led_ir,
  output logic [6:0]                  dc_comp,
  output logic [3:0]                  pga_gain,
  led_phase_scheduler_if.master       smp,
  output logic                        overrun,
  output logic                        busy
);

  localparam int unsigned NSAMP   = 1 << AVG_LOG2;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > NSAMP) ? SETTLE_CYCLES : NSAMP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned ACC_W   = 8 + AVG_LOG2;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACQ_LAST    = CNT_W'(NSAMP - 1);

  typedef enum logic [2:0] {
    IDLE,
    RED_SETTLE,
    RED_ACQ,
    IR_SETTLE,
    IR_ACQ
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       avg;
  logic             red_load, ir_load;

  logic [6:0]       red_op_q, ir_op_q;
  logic [3:0]       red_gain_q, ir_gain_q;

  logic             led_red_d, led_ir_d;
  logic [6:0]       dc_comp_d;
  logic [3:0]       pga_gain_d;

  logic             red_xfer, ir_xfer;
  logic             red_drop, ir_drop;

  // State, phase counter and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state sequencing, accumulation and end-of-phase result generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    acc_d    = acc_q;
    red_load = 1'b0;
    ir_load  = 1'b0;
    // Sum including the current sample; the final one is folded in here so
    // the result is ready on the edge that leaves the acquisition state.
    acc_sum  = acc_q + ACC_W'(adc);
    avg      = acc_sum[AVG_LOG2 +: 8];

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RED_SETTLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
        RED_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = RED_ACQ;
            cnt_d   = '0;
          end
        end
        RED_ACQ: begin
          acc_d = acc_sum;
          if (cnt_q == ACQ_LAST) begin
            state_d  = IR_SETTLE;
            cnt_d    = '0;
            acc_d    = '0;
            red_load = 1'b1;
          end
        end
        IR_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = IR_ACQ;
            cnt_d   = '0;
          end
        end
        IR_ACQ: begin
          acc_d = acc_sum;
          if (cnt_q == ACQ_LAST) begin
            state_d = RED_SETTLE;
            cnt_d   = '0;
            acc_d   = '0;
            ir_load = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      endcase
    end
  end

  // Calibration operating points, captured whenever the controller presents them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_op_q   <= '0;
      red_gain_q <= '0;
      ir_op_q    <= '0;
      ir_gain_q  <= '0;
    end else if (cal_valid) begin
      red_op_q   <= red_op;
      red_gain_q <= red_gain;
      ir_op_q    <= ir_op;
      ir_gain_q  <= ir_gain;
    end
  end

  // Front-end drive for the upcoming cycle; operating point only changes at phase entry
  always_comb begin
    led_red_d  = (state_d == RED_SETTLE) || (state_d == RED_ACQ);
    led_ir_d   = (state_d == IR_SETTLE)  || (state_d == IR_ACQ);
    dc_comp_d  = dc_comp;
    pga_gain_d = pga_gain;
    if (state_d == IDLE) begin
      dc_comp_d  = '0;
      pga_gain_d = '0;
    end else if ((state_d == RED_SETTLE) && (state_q != RED_SETTLE)) begin
      dc_comp_d  = red_op_q;
      pga_gain_d = red_gain_q;
    end else if ((state_d == IR_SETTLE) && (state_q != IR_SETTLE)) begin
      dc_comp_d  = ir_op_q;
      pga_gain_d = ir_gain_q;
    end
  end

  // Registered front-end drive and busy flag, switching on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_red  <= 1'b0;
      led_ir   <= 1'b0;
      dc_comp  <= '0;
      pga_gain <= '0;
      busy     <= 1'b0;
    end else begin
      led_red  <= led_red_d;
      led_ir   <= led_ir_d;
      dc_comp  <= dc_comp_d;
      pga_gain <= pga_gain_d;
      busy     <= (state_d != IDLE);
    end
  end

  // Handshake qualifiers: a load onto a still-pending, untransferred sample is dropped
  always_comb begin
    red_xfer = smp.red_valid & smp.red_ready;
    ir_xfer  = smp.ir_valid  & smp.ir_ready;
    red_drop = red_load & smp.red_valid & ~red_xfer;
    ir_drop  = ir_load  & smp.ir_valid  & ~ir_xfer;
  end

  // RED output register: holds the offered sample until the filter takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp.red_sample <= '0;
      smp.red_valid  <= 1'b0;
    end else if (red_load && !red_drop) begin
      smp.red_sample <= avg;
      smp.red_valid  <= 1'b1;
    end else if (red_xfer) begin
      smp.red_valid  <= 1'b0;
    end
  end

  // IR output register: holds the offered sample until the filter takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp.ir_sample <= '0;
      smp.ir_valid  <= 1'b0;
    end else if (ir_load && !ir_drop) begin
      smp.ir_sample <= avg;
      smp.ir_valid  <= 1'b1;
    end else if (ir_xfer) begin
      smp.ir_valid  <= 1'b0;
    end
  end

  // Single-cycle overrun pulse for any dropped result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= red_drop | ir_drop;
    end
  end

endmodule

// File: tb/tb_led_phase_scheduler.sv
// Directed bench for led_phase_scheduler with the default 8-cycle settle and
// 4-sample average (12-cycle phases). Outputs are sampled on the falling edge.
module tb_led_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       cal_valid;
  logic [6:0] red_op;
  logic [3:0] red_gain;
  logic [6:0] ir_op;
  logic [3:0] ir_gain;
  logic [7:0] adc;
  logic       led_red;
  logic       led_ir;
  logic [6:0] dc_comp;
  logic [3:0] pga_gain;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  led_phase_scheduler_if sif ();

  led_phase_scheduler #(
    .SETTLE_CYCLES (8),
    .AVG_LOG2      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cal_valid (cal_valid),
    .red_op    (red_op),
    .red_gain  (red_gain),
    .ir_op     (ir_op),
    .ir_gain   (ir_gain),
    .adc       (adc),
    .led_red   (led_red),
    .led_ir    (led_ir),
    .dc_comp   (dc_comp),
    .pga_gain  (pga_gain),
    .smp       (sif),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full 12-cycle phase, starting from the falling edge before it begins.
  // a0..a3 are the ADC values for the four acquisition samples. The pv_* args
  // describe the other channel, whose result loads on this phase's first edge.
  task automatic phase(input logic is_red,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] a2, input logic [7:0] a3,
                       input logic [6:0] exp_dc, input logic [3:0] exp_gain,
                       input logic pv_first, input logic [7:0] pv_sample,
                       input logic pv_last, input logic exp_ovr,
                       input logic do_cal);
    logic [7:0] av [4];
    av = '{a0, a1, a2, a3};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0 || i == 11) begin
        chk(is_red ? "red_ph_led_red" : "ir_ph_led_red", led_red, is_red);
        chk(is_red ? "red_ph_led_ir" : "ir_ph_led_ir", led_ir, !is_red);
        chk(is_red ? "red_ph_dc" : "ir_ph_dc", dc_comp, exp_dc);
        chk(is_red ? "red_ph_gain" : "ir_ph_gain", pga_gain, exp_gain);
        chk("busy_run", busy, 1'b1);
      end
      if (i == 0) begin
        chk(is_red ? "ir_valid_first" : "red_valid_first",
            is_red ? sif.ir_valid : sif.red_valid, pv_first);
        if (pv_first)
          chk(is_red ? "ir_sample" : "red_sample",
              is_red ? sif.ir_sample : sif.red_sample, pv_sample);
        chk("overrun_first", overrun, exp_ovr);
      end
      if (i == 1) chk("overrun_second", overrun, 1'b0);
      if (i == 11)
        chk(is_red ? "ir_valid_last" : "red_valid_last",
            is_red ? sif.ir_valid : sif.red_valid, pv_last);
      if (do_cal && i == 9) begin
        cal_valid = 1'b1;
        red_op    = 7'd90;
      end
      if (do_cal && i == 10) cal_valid = 1'b0;
      if (i >= 8) adc = av[i-8];
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    cal_valid     = 1'b0;
    red_op        = '0;
    red_gain      = '0;
    ir_op         = '0;
    ir_gain       = '0;
    adc           = '0;
    sif.red_ready = 1'b0;
    sif.ir_ready  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_led_red", led_red, 1'b0);
    chk("rst_led_ir", led_ir, 1'b0);
    chk("rst_dc", dc_comp, 7'd0);
    chk("rst_gain", pga_gain, 4'd0);
    chk("rst_red_valid", sif.red_valid, 1'b0);
    chk("rst_ir_valid", sif.ir_valid, 1'b0);
    chk("rst_red_sample", sif.red_sample, 8'd0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);

    rst_n     = 1'b1;
    cal_valid = 1'b1;
    red_op    = 7'd40;
    red_gain  = 4'd3;
    ir_op     = 7'd70;
    ir_gain   = 4'd5;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    cal_valid     = 1'b0;
    enable        = 1'b1;
    sif.red_ready = 1'b1;
    sif.ir_ready  = 1'b1;

    // Basic alternation with constant ADC levels
    phase(1'b1, 8'd100, 8'd100, 8'd100, 8'd100, 7'd40, 4'd3, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
    phase(1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 7'd70, 4'd5, 1'b1, 8'd100, 1'b0, 1'b0, 1'b0);
    // Averaging with truncation: (10+20+30+41)>>2 = 25
    phase(1'b1, 8'd10,  8'd20,  8'd30,  8'd41,  7'd40, 4'd3, 1'b1, 8'd200, 1'b0, 1'b0, 1'b0);
    phase(1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 7'd70, 4'd5, 1'b1, 8'd25,  1'b0, 1'b0, 1'b0);
    // RED filter stalls across two completions: 100 held, 60 dropped
    sif.red_ready = 1'b0;
    phase(1'b1, 8'd100, 8'd100, 8'd100, 8'd100, 7'd40, 4'd3, 1'b1, 8'd200, 1'b0, 1'b0, 1'b0);
    phase(1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 7'd70, 4'd5, 1'b1, 8'd100, 1'b1, 1'b0, 1'b0);
    phase(1'b1, 8'd60,  8'd60,  8'd60,  8'd60,  7'd40, 4'd3, 1'b1, 8'd200, 1'b0, 1'b0, 1'b0);
    phase(1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 7'd70, 4'd5, 1'b1, 8'd100, 1'b1, 1'b1, 1'b0);
    // New calibration mid-acquisition must not disturb the current phase
    phase(1'b1, 8'd80,  8'd80,  8'd80,  8'd80,  7'd40, 4'd3, 1'b1, 8'd200, 1'b0, 1'b0, 1'b1);
    // Ready rises on the loading edge: 100 transferred, 80 replaces it, no overrun
    sif.red_ready = 1'b1;
    phase(1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 7'd70, 4'd5, 1'b1, 8'd80,  1'b0, 1'b0, 1'b0);
    phase(1'b1, 8'd50,  8'd50,  8'd50,  8'd50,  7'd90, 4'd3, 1'b1, 8'd200, 1'b0, 1'b0, 1'b0);

    // Disable during the second IR acquisition cycle
    @(negedge clk);
    chk("ir6_led_ir", led_ir, 1'b1);
    chk("ir6_dc", dc_comp, 7'd70);
    chk("ir6_red_valid", sif.red_valid, 1'b1);
    chk("ir6_red_sample", sif.red_sample, 8'd50);
    adc = 8'd200;
    repeat (9) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_busy", busy, 1'b0);
    chk("dis_led_ir", led_ir, 1'b0);
    chk("dis_led_red", led_red, 1'b0);
    chk("dis_dc", dc_comp, 7'd0);
    chk("dis_gain", pga_gain, 4'd0);
    chk("dis_ir_valid", sif.ir_valid, 1'b0);
    @(negedge clk);
    chk("dis_ir_valid2", sif.ir_valid, 1'b0);
    chk("dis_busy2", busy, 1'b0);
    enable = 1'b1;
    // Restart always begins with RED, using the updated calibration
    phase(1'b1, 8'd30,  8'd30,  8'd30,  8'd30,  7'd90, 4'd3, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
    sif.red_ready = 1'b0;
    phase(1'b0, 8'd200, 8'd200, 8'd200, 8'd200, 7'd70, 4'd5, 1'b1, 8'd30,  1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RED acquisition with a pending sample
    repeat (10) @(negedge clk);
    chk("pre_rst_led_red", led_red, 1'b1);
    chk("pre_rst_red_valid", sif.red_valid, 1'b1);
    chk("pre_rst_red_sample", sif.red_sample, 8'd30);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led_red", led_red, 1'b0);
    chk("arst_dc", dc_comp, 7'd0);
    chk("arst_red_valid", sif.red_valid, 1'b0);
    chk("arst_red_sample", sif.red_sample, 8'd0);
    chk("arst_overrun", overrun, 1'b0);
    chk("arst_busy", busy, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_led_red", led_red, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
